// File: rtl/drift_violation_detection_pkg.sv
// Shared types for the drift violation detector: clock/reset domain bundle,
// recovered edge events and detector FSM states.
package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int PERIOD_COUNTER_WIDTH = 16;

    typedef logic [PERIOD_COUNTER_WIDTH-1:0] period_t;

    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
        logic any_valid_edge;
    } recovered_events_s;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        TRACKING
    } drift_detect_state_e;
endpackage

// File: rtl/drift_violation_detection_window_compare.sv
// Checks one measured phase duration against expected +/- tolerance.
module drift_window_compare
    import clks_alot_p::*;
(
    input  logic [PERIOD_COUNTER_WIDTH-1:0] measured_i,
    input  logic [PERIOD_COUNTER_WIDTH-1:0] expected_i,
    input  logic [PERIOD_COUNTER_WIDTH-1:0] tolerance_i,
    output logic                            too_long_o,
    output logic                            too_short_o
);
    localparam int W = PERIOD_COUNTER_WIDTH;

    logic [W:0]   upper_wide;
    logic [W:0]   lower_wide;
    logic [W-1:0] upper;
    logic [W-1:0] lower;

    // One extra bit catches overflow/borrow so the window clamps instead of wrapping.
    always_comb begin
        upper_wide  = {1'b0, expected_i} + {1'b0, tolerance_i};
        lower_wide  = {1'b0, expected_i} - {1'b0, tolerance_i};
        upper       = upper_wide[W] ? '1 : upper_wide[W-1:0];
        lower       = lower_wide[W] ? '0 : lower_wide[W-1:0];
        too_long_o  = (measured_i > upper) || (measured_i == '1);
        too_short_o = !too_long_o && (measured_i < lower);
    end
endmodule

// File: rtl/drift_violation_detection.sv
// Measures high/low phase durations between recovered edges and pulses a
// violation when a phase falls outside its expected window.
//
// state    | meaning
// IDLE     | detection disabled, counter held, no judgements
// ARMING   | waiting for a clean single edge to start a measurement
// TRACKING | every single edge closes a phase and is judged
module drift_violation_detection
    import common_p::*;
    import clks_alot_p::*;
(
    input  clk_dom_s                        sys_dom_i,
    input  logic                            recovery_en_i,
    input  logic                            clear_state_i,
    input  logic [PERIOD_COUNTER_WIDTH-1:0] expected_high_period_i,
    input  logic [PERIOD_COUNTER_WIDTH-1:0] expected_low_period_i,
    input  logic [PERIOD_COUNTER_WIDTH-1:0] drift_tolerance_i,
    input  recovered_events_s               io_events_i,
    output recovered_events_s               io_events_o,
    output logic                            high_positive_drift_violation_o,
    output logic                            high_negative_drift_violation_o,
    output logic                            low_positive_drift_violation_o,
    output logic                            low_negative_drift_violation_o
);
    logic clk;
    logic rst;
    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    drift_detect_state_e state_q, state_d;
    period_t             cnt_q, cnt_d;
    recovered_events_s   events_q, events_d;
    logic                high_pos_q, high_pos_d;
    logic                high_neg_q, high_neg_d;
    logic                low_pos_q, low_pos_d;
    logic                low_neg_q, low_neg_d;

    logic    high_long, high_short, low_long, low_short;
    logic    single_edge, glitch_edge;
    period_t cnt_inc;

    drift_window_compare u_high_cmp (
        .measured_i  (cnt_q),
        .expected_i  (expected_high_period_i),
        .tolerance_i (drift_tolerance_i),
        .too_long_o  (high_long),
        .too_short_o (high_short)
    );

    drift_window_compare u_low_cmp (
        .measured_i  (cnt_q),
        .expected_i  (expected_low_period_i),
        .tolerance_i (drift_tolerance_i),
        .too_long_o  (low_long),
        .too_short_o (low_short)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        events_d    = io_events_i;
        high_pos_d  = 1'b0;
        high_neg_d  = 1'b0;
        low_pos_d   = 1'b0;
        low_neg_d   = 1'b0;
        single_edge = io_events_i.rising_edge ^ io_events_i.falling_edge;
        glitch_edge = io_events_i.rising_edge & io_events_i.falling_edge;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + period_t'(1);

        if (!recovery_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMING;
                end
                ARMING: begin
                    cnt_d = cnt_inc;
                    if (!clear_state_i && single_edge) begin
                        state_d = TRACKING;
                        cnt_d   = period_t'(1);
                    end
                end
                TRACKING: begin
                    cnt_d = cnt_inc;
                    if (clear_state_i || glitch_edge) begin
                        state_d = ARMING;
                    end else if (single_edge) begin
                        cnt_d      = period_t'(1);
                        high_pos_d = io_events_i.falling_edge && high_long;
                        high_neg_d = io_events_i.falling_edge && high_short;
                        low_pos_d  = io_events_i.rising_edge && low_long;
                        low_neg_d  = io_events_i.rising_edge && low_short;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            events_q   <= '0;
            high_pos_q <= 1'b0;
            high_neg_q <= 1'b0;
            low_pos_q  <= 1'b0;
            low_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            events_q   <= events_d;
            high_pos_q <= high_pos_d;
            high_neg_q <= high_neg_d;
            low_pos_q  <= low_pos_d;
            low_neg_q  <= low_neg_d;
        end
    end

    assign io_events_o                     = events_q;
    assign high_positive_drift_violation_o = high_pos_q;
    assign high_negative_drift_violation_o = high_neg_q;
    assign low_positive_drift_violation_o  = low_pos_q;
    assign low_negative_drift_violation_o  = low_neg_q;
endmodule

// File: tb/tb_drift_violation_detection.sv
// Scoreboard bench: each driven edge queues its expected delayed event and
// violation vector; a negedge monitor pops and compares on io_events_o.
module tb_drift_violation_detection;
    import common_p::*;
    import clks_alot_p::*;

    localparam logic [3:0] V_NONE = 4'b0000;
    localparam logic [3:0] V_HP   = 4'b1000;
    localparam logic [3:0] V_HN   = 4'b0100;
    localparam logic [3:0] V_LP   = 4'b0010;
    localparam logic [3:0] V_LN   = 4'b0001;

    typedef struct packed {
        logic [2:0] ev;
        logic [3:0] viol;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              rst;
    clk_dom_s          sys_dom;
    logic              recovery_en;
    logic              clear_state;
    period_t           exp_high;
    period_t           exp_low;
    period_t           tol;
    recovered_events_s ev_in;
    recovered_events_s ev_out;
    logic              hp, hn, lp, ln;

    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    assign sys_dom = {clk, rst};

    always #5 clk = ~clk;

    drift_violation_detection dut (
        .sys_dom_i                       (sys_dom),
        .recovery_en_i                   (recovery_en),
        .clear_state_i                   (clear_state),
        .expected_high_period_i          (exp_high),
        .expected_low_period_i           (exp_low),
        .drift_tolerance_i               (tol),
        .io_events_i                     (ev_in),
        .io_events_o                     (ev_out),
        .high_positive_drift_violation_o (hp),
        .high_negative_drift_violation_o (hn),
        .low_positive_drift_violation_o  (lp),
        .low_negative_drift_violation_o  (ln)
    );

    always @(negedge clk) begin
        sb_item_t got;
        sb_item_t want;
        got = {ev_out, hp, hn, lp, ln};
        if (ev_out.any_valid_edge) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got ev=%b viol=%b, required no output", got.ev, got.viol);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL edge_response @%0t: got ev=%b viol=%b, required ev=%b viol=%b",
                             $time, got.ev, got.viol, want.ev, want.viol);
                end
            end
        end else begin
            n_checks++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL stray_output @%0t: got ev=%b viol=%b, required all zero",
                         $time, got.ev, got.viol);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            ev_in = '0;
            tick();
        end
    endtask

    task automatic edge_ev(input logic r, input logic f, input logic [3:0] viol);
        ev_in = {r, f, r | f};
        sb_q.push_back({r, f, r | f, viol});
        tick();
        ev_in = '0;
    endtask

    // One edge followed by enough quiet cycles that the next edge lands gap cycles later.
    task automatic step(input logic r, input logic f, input logic [3:0] viol, input int gap);
        edge_ev(r, f, viol);
        quiet(gap - 1);
    endtask

    initial begin
        rst         = 1'b1;
        recovery_en = 1'b0;
        clear_state = 1'b0;
        exp_high    = 16'd10;
        exp_low     = 16'd10;
        tol         = 16'd2;
        ev_in       = '0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({ev_out, hp, hn, lp, ln} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ev=%b viol=%b, required all zero", ev_out, {hp, hn, lp, ln});
        end
        tick();
        rst = 1'b0;
        recovery_en = 1'b1;
        quiet(3);

        // nominal and window boundaries, window [8,12]
        step(1, 0, V_NONE, 10);
        step(0, 1, V_NONE, 10);
        step(1, 0, V_NONE, 13);
        step(0, 1, V_HP,   12);
        step(1, 0, V_NONE, 12);
        step(0, 1, V_NONE, 7);
        step(1, 0, V_LN,   8);
        step(0, 1, V_NONE, 8);
        step(1, 0, V_NONE, 7);
        step(0, 1, V_HN,   14);
        step(1, 0, V_LP,   5);

        // expected_low=1, tol=2: window [0,3]; threshold changed mid-phase
        edge_ev(0, 1, V_HN);
        exp_low = 16'd1;
        step(1, 0, V_NONE, 10);
        step(0, 1, V_NONE, 4);
        edge_ev(1, 0, V_LP);
        exp_low = 16'd10;
        quiet(9);
        step(0, 1, V_NONE, 10);

        // simultaneous edges re-arm; next edge only arms
        step(1, 1, V_NONE, 3);
        step(1, 0, V_NONE, 10);

        // clear mid-phase
        edge_ev(0, 1, V_NONE);
        quiet(5);
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
        quiet(7);
        step(1, 0, V_NONE, 5);
        step(0, 1, V_HN, 10);

        // clear coincident with an edge discards it
        clear_state = 1'b1;
        edge_ev(1, 0, V_NONE);
        clear_state = 1'b0;
        quiet(2);
        step(0, 1, V_NONE, 13);
        step(1, 0, V_LP, 4);

        // reset mid-phase
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        quiet(3);
        step(0, 1, V_NONE, 13);
        step(1, 0, V_LP, 4);

        // disabled: edges pass through, nothing judged
        recovery_en = 1'b0;
        quiet(2);
        step(0, 1, V_NONE, 3);
        recovery_en = 1'b1;
        quiet(2);
        step(1, 0, V_NONE, 13);
        step(0, 1, V_HP, 10);

        // saturation counts as positive drift even against an all-ones window
        edge_ev(1, 0, V_NONE);
        exp_high = 16'hFFFF;
        tol      = 16'd0;
        quiet(65535);
        edge_ev(0, 1, V_HP);
        quiet(3);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries pending, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/drift_violation_detection.md
DRIFT_VIOLATION_DETECTION -- requirements
Module: drift_violation_detection

Interface
REQ-001 SHALL have parameter none; all widths come from clks_alot_p (PERIOD_COUNTER_WIDTH, default 16, phase-duration counter width).
REQ-002 SHALL have port sys_dom_i, input, common_p::clk_dom_s, carrying the single clock and its synchronous, active-high reset.
REQ-003 SHALL have port recovery_en_i, input, 1, detection enable.
REQ-004 SHALL have port clear_state_i, input, 1, restart measurement (re-arm).
REQ-005 SHALL have port expected_high_period_i, input, PERIOD_COUNTER_WIDTH, nominal high-phase duration in sys cycles.
REQ-006 SHALL have port expected_low_period_i, input, PERIOD_COUNTER_WIDTH, nominal low-phase duration.
REQ-007 SHALL have port drift_tolerance_i, input, PERIOD_COUNTER_WIDTH, allowed +/- deviation.
REQ-008 SHALL have port io_events_i, input, clks_alot_p::recovered_events_s, using fields rising_edge, falling_edge, any_valid_edge.
REQ-009 SHALL have port io_events_o, output, clks_alot_p::recovered_events_s, io_events_i delayed one cycle, aligned with violation outputs.
REQ-010 SHALL have outputs high_positive_drift_violation_o, high_negative_drift_violation_o, low_positive_drift_violation_o, low_negative_drift_violation_o, each 1 bit, single-cycle registered pulses.

Function
REQ-011 SHALL define duration D = cycles between consecutive edge cycles (edges at t0, t1 -> D = t1 - t0).
REQ-012 SHALL implement D with a phase counter loaded with 1 on each edge cycle and incremented otherwise, saturating at all-ones.
REQ-013 SHALL compute windows at width+1: upper = min(expected + tolerance, all-ones); lower = max(expected - tolerance, 0), with no wrap-around.
REQ-014 SHALL, on a falling_edge, judge the high phase: D > upper_high -> high_positive; D < lower_high -> high_negative.
REQ-015 SHALL, on a rising_edge, judge the low phase the same way against the low window.
REQ-016 SHALL flag a saturated counter as positive drift for the phase being judged.
REQ-017 SHALL use D equal to a window bound as in-window, with no violation.
REQ-018 SHALL have an FSM with states IDLE, ARMING and TRACKING.
REQ-019 IDLE SHALL be entered when recovery_en_i=0 from any state; the counter holds and violations are 0.
REQ-020 IDLE SHALL go to ARMING when recovery_en_i=1.
REQ-021 ARMING SHALL go to TRACKING on the first single edge, loading the counter with no judgement.
REQ-022 TRACKING SHALL judge every single edge per REQ-014..017.
REQ-023 SHALL, when rising_edge and falling_edge assert in the same cycle, make no judgement and go to ARMING (glitch), re-arming on the next single edge.
REQ-024 SHALL, on clear_state_i=1 while enabled, go to ARMING next cycle, discarding any edge in that cycle (no judgement), with clear taking priority over edges.
REQ-025 SHALL register violation outputs one cycle after the judged edge, coincident with io_events_o.any_valid_edge.
REQ-026 SHALL assert at most one violation output per cycle.
REQ-027 SHALL pass io_events_o through irrespective of FSM state.
REQ-028 SHALL sample threshold inputs on the edge cycle, so mid-phase changes affect only later judgements.

Reset
REQ-029 SHALL, on synchronous reset, set FSM to IDLE, phase counter to 0, all violation outputs to 0 and io_events_o to all-zero.
REQ-030 SHALL, on reset mid-phase, discard the partial measurement, with the first post-reset edge only arming.

Structure
REQ-031 SHALL place PERIOD_COUNTER_WIDTH and the state enum drift_detect_state_e in clks_alot_p.
REQ-032 SHALL have one sub-module drift_window_compare (measured, expected, tolerance -> too_long, too_short), instanced twice (high, low).
REQ-033 SHALL have outputs that connect directly to drift_violation_tracking (io_events_o.any_valid_edge as its event input).

Verification (expected_high=expected_low=10, tolerance=2)
REQ-034 SHALL check that edges every 10 cycles, alternating, give all violations 0 after arming; io_events_o is io_events_i delayed by one cycle.
REQ-035 SHALL check that a high phase of 13 gives high_positive pulse one cycle after the falling edge; a high phase of 12 gives none.
REQ-036 SHALL check that a low phase of 7 gives low_negative pulse; expected=1 with tolerance=2 gives lower=0 and a 1-cycle phase gives no violation.
REQ-037 SHALL check that rising and falling edges in the same cycle give no pulse, re-arming, and the next single edge gives no judgement.
REQ-038 SHALL check that clear_state_i or reset mid-phase makes the first subsequent edge judge nothing and the following edge judge normally.
REQ-039 SHALL check that with PERIOD_COUNTER_WIDTH=4, no edge for 20 cycles saturates the counter and the next falling edge gives high_positive.
